// File: rtl/soft_int_ctrl.sv
// Software/hardware interrupt controller. In-flight ECFG/ESTAT CSR writes are overlaid on the
// committed shadows so that a pending interrupt is seen as soon as the write leaves EX.
module soft_int_ctrl #(
    parameter int          STAGES     = 3,
    parameter int          INT_W      = 13,
    parameter logic [13:0] ADDR_ECFG  = 14'h4,
    parameter logic [13:0] ADDR_ESTAT = 14'h5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ex_valid,
    input  logic             ex_csr_we,
    input  logic [13:0]      ex_csr_addr,
    input  logic [31:0]      ex_csr_wdata,
    input  logic [31:0]      ex_csr_wmask,
    input  logic             pipe_adv,
    input  logic             flush,
    input  logic [INT_W-3:0] hw_int,
    input  logic             crmd_ie,
    input  logic             int_take,
    input  logic             ertn_commit,
    output logic             int_req,
    output logic [INT_W-1:0] int_cause,
    output logic [INT_W-1:0] lie_q,
    output logic [1:0]       is_soft_q,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2,
        BAD  = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             ecfg;
        logic [INT_W-1:0] d;
        logic [INT_W-1:0] m;
    } slot_t;

    slot_t            slots [STAGES];
    slot_t            ex_slot;
    logic             ex_is_ecfg;
    logic             ex_is_estat;
    logic [INT_W-1:0] eff_lie;
    logic [1:0]       eff_is;
    logic [INT_W-1:0] vec;
    logic             fire;
    state_t           state_q;
    state_t           state_next;
    logic             cause_load;
    logic             unused_bits;

    assign ex_is_ecfg  = (ex_csr_addr == ADDR_ECFG);
    assign ex_is_estat = (ex_csr_addr == ADDR_ESTAT);
    assign ex_slot     = '{valid: ex_valid & ex_csr_we & (ex_is_ecfg | ex_is_estat),
                           ecfg:  ex_is_ecfg,
                           d:     ex_csr_wdata[INT_W-1:0],
                           m:     ex_csr_wmask[INT_W-1:0]};
    assign unused_bits = ^{ex_csr_wdata[31:INT_W], ex_csr_wmask[31:INT_W]};

    // slot[0] is the youngest in-flight write, slot[STAGES-1] the next to commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the whole slot array is reset, not just valid, so no X can reach the overlay mux.
            for (int i = 0; i < STAGES; i++) slots[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) slots[i].valid <= 1'b0;
        end else if (pipe_adv) begin
            slots[0] <= ex_slot;
            for (int i = 1; i < STAGES; i++) slots[i] <= slots[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lie_q     <= '0;
            is_soft_q <= '0;
        end else if (pipe_adv && !flush && slots[STAGES-1].valid) begin
            if (slots[STAGES-1].ecfg)
                lie_q <= (lie_q & ~slots[STAGES-1].m) | (slots[STAGES-1].d & slots[STAGES-1].m);
            else
                is_soft_q <= (is_soft_q & ~slots[STAGES-1].m[1:0])
                           | (slots[STAGES-1].d[1:0] & slots[STAGES-1].m[1:0]);
        end
    end

    // Overlay oldest first so the youngest write wins on every masked bit.
    always_comb begin
        // NOTE: blocking assignments here are intentional; each overlay step reads the previous one.
        eff_lie = lie_q;
        eff_is  = is_soft_q;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (slots[i].valid) begin
                if (slots[i].ecfg) eff_lie = (eff_lie & ~slots[i].m) | (slots[i].d & slots[i].m);
                else               eff_is  = (eff_is & ~slots[i].m[1:0]) | (slots[i].d[1:0] & slots[i].m[1:0]);
            end
        end
        if (ex_slot.valid) begin
            if (ex_slot.ecfg) eff_lie = (eff_lie & ~ex_slot.m) | (ex_slot.d & ex_slot.m);
            else              eff_is  = (eff_is & ~ex_slot.m[1:0]) | (ex_slot.d[1:0] & ex_slot.m[1:0]);
        end
    end

    assign vec  = {hw_int, eff_is} & eff_lie;
    assign fire = (|vec) & crmd_ie;

    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_next = state_q;
        cause_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_next = PEND;
                    cause_load = 1'b1;
                end
            end
            PEND: begin
                cause_load = 1'b1;
                if (int_take)   state_next = SERV;
                else if (!fire) state_next = IDLE;
            end
            SERV: begin
                if (ertn_commit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            int_req   <= 1'b0;
            int_cause <= '0;
        end else begin
            state_q <= state_next;
            int_req <= (state_next == PEND);
            if (cause_load) int_cause <= vec;
        end
    end

    assign state = state_q;

endmodule
